// File: rtl/rs_div_ooo.sv
// rs_div_ooo: divide reservation station with an embedded radix-2 divider.
//
// Holds up to DEPTH RV32M divide/remainder ops, wakes dependent operands by
// snooping NUM_WB writeback channels, and issues the oldest ready op into a
// 32-iteration restoring divider. Results leave on a single writeback port.
//
// Ports:
//   clk, rst (sync, active-low), hci_rdy (global enable), flush (squash all)
//   in_en/op_type/vdest_id/op1_dependent/op1/op2_dependent/op2 : new op
//   wb_en/wb_vregid/wb_val   : snooped writeback channels (lowest index wins)
//   writeback_en/_vregid/_val : one-cycle result pulse
//   full     : registered, occupancy == DEPTH
//   div_busy : registered, divider in RUN or DONE
//
// Handshake: there is no ready output. A new op is taken on an edge where
// in_en=1, full=0, flush=0 and hci_rdy=1; with full=1 the op is dropped, so
// the producer must watch full before asserting in_en.
module rs_div_ooo #(
    parameter int DEPTH  = 8,
    parameter int NUM_WB = 3,
    parameter int TAG_W  = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    hci_rdy,
    input  logic                    flush,
    input  logic                    in_en,
    input  logic [2:0]              op_type,
    input  logic [TAG_W-1:0]        vdest_id,
    input  logic                    op1_dependent,
    input  logic [31:0]             op1,
    input  logic                    op2_dependent,
    input  logic [31:0]             op2,
    input  logic [NUM_WB-1:0]       wb_en,
    input  logic [NUM_WB*TAG_W-1:0] wb_vregid,
    input  logic [NUM_WB*32-1:0]    wb_val,
    output logic                    writeback_en,
    output logic [TAG_W-1:0]        writeback_vregid,
    output logic [31:0]             writeback_val,
    output logic                    full,
    output logic                    div_busy
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Station entries; age_q[i][j]=1 means entry i is older than entry j.
    logic [DEPTH-1:0] vld_q, vld_d, dep1_q, dep1_d, dep2_q, dep2_d;
    logic [1:0]       eop_q  [DEPTH];
    logic [1:0]       eop_d  [DEPTH];
    logic [TAG_W-1:0] etag_q [DEPTH];
    logic [TAG_W-1:0] etag_d [DEPTH];
    logic [31:0]      val1_q [DEPTH];
    logic [31:0]      val1_d [DEPTH];
    logic [31:0]      val2_q [DEPTH];
    logic [31:0]      val2_d [DEPTH];
    logic [DEPTH-1:0] age_q  [DEPTH];
    logic [DEPTH-1:0] age_d  [DEPTH];
    logic [CNT_W-1:0] ocnt_q, ocnt_d;
    logic             full_q, full_d, busy_q, busy_d;

    // Divider state; div_state_q is the FSM state visible for checkers.
    logic [1:0]       div_state_q, div_state_d;
    logic [4:0]       it_q, it_d;
    logic [31:0]      rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic             negq_q, negq_d, negr_q, negr_d, isrem_q, isrem_d;
    logic [TAG_W-1:0] dtag_q, dtag_d;
    logic             wbe_q, wbe_d;
    logic [TAG_W-1:0] wbt_q, wbt_d;
    logic [31:0]      wbv_q, wbv_d;

    logic             unused_op_bit;
    assign unused_op_bit = op_type[2];

    // Returns {hit, value} for a tag; the lowest matching channel wins.
    function automatic logic [32:0] snoop(input logic [TAG_W-1:0] tag);
        logic [32:0] r;
        r = '0;
        for (int k = NUM_WB - 1; k >= 0; k--) begin
            if (wb_en[k] && wb_vregid[k*TAG_W +: TAG_W] == tag) r = {1'b1, wb_val[k*32 +: 32]};
        end
        return r;
    endfunction

    logic [DEPTH-1:0] rdy, sel_oh;
    logic [IDX_W-1:0] sel_idx, free_idx;
    logic             any_rdy, div_free, alloc, bypass, alloc_ent, issue_ent, cap;
    logic [32:0]      s_in1, s_in2;
    logic             in_dep1, in_dep2;
    logic [31:0]      in_v1, in_v2;

    always_comb begin
        sel_oh   = '0;
        sel_idx  = '0;
        free_idx = '0;
        for (int i = 0; i < DEPTH; i++) rdy[i] = vld_q[i] & ~dep1_q[i] & ~dep2_q[i];
        // Oldest ready: no other ready entry is older than it.
        for (int i = 0; i < DEPTH; i++) begin
            sel_oh[i] = rdy[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && rdy[j] && age_q[j][i]) sel_oh[i] = 1'b0;
            end
        end
        for (int i = 0; i < DEPTH; i++) if (sel_oh[i]) sel_idx = IDX_W'(i);
        for (int i = DEPTH - 1; i >= 0; i--) if (!vld_q[i]) free_idx = IDX_W'(i);
        any_rdy = |rdy;

        s_in1   = snoop(op1[TAG_W-1:0]);
        s_in2   = snoop(op2[TAG_W-1:0]);
        in_dep1 = op1_dependent & ~s_in1[32];
        in_dep2 = op2_dependent & ~s_in2[32];
        in_v1   = (op1_dependent && s_in1[32]) ? s_in1[31:0] : op1;
        in_v2   = (op2_dependent && s_in2[32]) ? s_in2[31:0] : op2;

        // DONE hands the divider back on its own edge, so it counts as free.
        div_free  = (div_state_q != S_RUN);
        alloc     = in_en & ~full_q & ~flush;
        issue_ent = div_free & any_rdy;
        bypass    = alloc & div_free & ~any_rdy & ~in_dep1 & ~in_dep2;
        alloc_ent = alloc & ~bypass;
        cap       = issue_ent | bypass;
    end

    // Entry bookkeeping: wake-up, issue, allocation, flush.
    always_comb begin
        logic [32:0] sw;
        vld_d  = vld_q;  dep1_d = dep1_q; dep2_d = dep2_q;
        eop_d  = eop_q;  etag_d = etag_q; val1_d = val1_q;
        val2_d = val2_q; age_d  = age_q;
        for (int i = 0; i < DEPTH; i++) begin
            sw = snoop(val1_q[i][TAG_W-1:0]);
            if (vld_q[i] && dep1_q[i] && sw[32]) begin
                dep1_d[i] = 1'b0;
                val1_d[i] = sw[31:0];
            end
            sw = snoop(val2_q[i][TAG_W-1:0]);
            if (vld_q[i] && dep2_q[i] && sw[32]) begin
                dep2_d[i] = 1'b0;
                val2_d[i] = sw[31:0];
            end
        end
        if (issue_ent) vld_d[sel_idx] = 1'b0;
        if (alloc_ent) begin
            vld_d[free_idx]  = 1'b1;
            dep1_d[free_idx] = in_dep1;
            dep2_d[free_idx] = in_dep2;
            eop_d[free_idx]  = op_type[1:0];
            etag_d[free_idx] = vdest_id;
            val1_d[free_idx] = in_v1;
            val2_d[free_idx] = in_v2;
            // New entry is younger than every other entry.
            age_d[free_idx]  = '0;
            for (int j = 0; j < DEPTH; j++) begin
                if (j != int'(free_idx)) age_d[j][free_idx] = 1'b1;
            end
        end
        ocnt_d = ocnt_q + CNT_W'(alloc_ent) - CNT_W'(issue_ent);
        if (flush) begin
            vld_d  = '0;
            ocnt_d = '0;
        end
        full_d = (ocnt_d == CNT_W'(DEPTH));
    end

    // Divider: capture, restoring iteration, sign fix-up.
    always_comb begin
        logic [1:0]  c_op;
        logic [31:0] c_a, c_b, ma, mb, qf, rf;
        logic [32:0] trial, diff;
        logic        sgn, an, bn;
        div_state_d = div_state_q;
        it_d = it_q; rem_d = rem_q; quo_d = quo_q; dvs_d = dvs_q;
        negq_d = negq_q; negr_d = negr_q; isrem_d = isrem_q; dtag_d = dtag_q;
        wbe_d = 1'b0; wbt_d = wbt_q; wbv_d = wbv_q;

        trial = {rem_q, quo_q[31]};
        diff  = trial - {1'b0, dvs_q};
        qf    = negq_q ? -quo_q : quo_q;
        rf    = negr_q ? -rem_q : rem_q;

        case (div_state_q)
            S_RUN: begin
                if (!diff[32]) begin
                    rem_d = diff[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = trial[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                it_d = it_q + 5'd1;
                if (it_q == 5'd31) div_state_d = S_DONE;
            end
            S_DONE: begin
                wbe_d       = 1'b1;
                wbt_d       = dtag_q;
                wbv_d       = isrem_q ? rf : qf;
                div_state_d = S_IDLE;
            end
            default: ;
        endcase

        c_op   = issue_ent ? eop_q[sel_idx]  : op_type[1:0];
        c_a    = issue_ent ? val1_q[sel_idx] : in_v1;
        c_b    = issue_ent ? val2_q[sel_idx] : in_v2;
        sgn    = ~c_op[0];
        an     = sgn & c_a[31];
        bn     = sgn & c_b[31];
        ma     = an ? -c_a : c_a;
        mb     = bn ? -c_b : c_b;
        if (cap) begin
            isrem_d = c_op[1];
            dtag_d  = issue_ent ? etag_q[sel_idx] : vdest_id;
            it_d    = '0;
            dvs_d   = mb;
            if (c_b == 32'd0) begin
                // Early-out values are final, so the sign fix-up is disabled.
                div_state_d = S_DONE;
                quo_d = 32'hFFFF_FFFF; rem_d = c_a; negq_d = 1'b0; negr_d = 1'b0;
            end else if (sgn && c_a == 32'h8000_0000 && c_b == 32'hFFFF_FFFF) begin
                div_state_d = S_DONE;
                quo_d = 32'h8000_0000; rem_d = '0; negq_d = 1'b0; negr_d = 1'b0;
            end else begin
                div_state_d = S_RUN;
                quo_d = ma; rem_d = '0; negq_d = an ^ bn; negr_d = an;
            end
        end
        if (flush) begin
            div_state_d = S_IDLE;
            wbe_d       = 1'b0;
        end
        busy_d = (div_state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q <= '0; ocnt_q <= '0; full_q <= 1'b0; busy_q <= 1'b0;
            div_state_q <= S_IDLE;
            wbe_q <= 1'b0; wbt_q <= '0; wbv_q <= '0;
        end else if (hci_rdy) begin
            vld_q <= vld_d; ocnt_q <= ocnt_d; full_q <= full_d; busy_q <= busy_d;
            div_state_q <= div_state_d;
            wbe_q <= wbe_d; wbt_q <= wbt_d; wbv_q <= wbv_d;
        end
    end

    // Payload registers only matter while qualified by valid/state.
    always_ff @(posedge clk) begin
        if (hci_rdy) begin
            dep1_q <= dep1_d; dep2_q <= dep2_d; eop_q <= eop_d; etag_q <= etag_d;
            val1_q <= val1_d; val2_q <= val2_d; age_q <= age_d;
            it_q <= it_d; rem_q <= rem_d; quo_q <= quo_d; dvs_q <= dvs_d;
            negq_q <= negq_d; negr_q <= negr_d; isrem_q <= isrem_d; dtag_q <= dtag_d;
        end
    end

    assign writeback_en     = wbe_q;
    assign writeback_vregid = wbt_q;
    assign writeback_val    = wbv_q;
    assign full             = full_q;
    assign div_busy         = busy_q;
endmodule

// File: tb/tb_rs_div_ooo.sv
module tb_rs_div_ooo;
    localparam int DEPTH  = 4;
    localparam int NUM_WB = 3;
    localparam int TAG_W  = 5;
    localparam int EW     = TAG_W + 32;

    logic                    clk = 1'b0;
    logic                    rst, hci_rdy, flush, in_en;
    logic [2:0]              op_type;
    logic [TAG_W-1:0]        vdest_id;
    logic                    op1_dependent, op2_dependent;
    logic [31:0]             op1, op2;
    logic [NUM_WB-1:0]       wb_en;
    logic [NUM_WB*TAG_W-1:0] wb_vregid;
    logic [NUM_WB*32-1:0]    wb_val;
    logic                    writeback_en, full, div_busy;
    logic [TAG_W-1:0]        writeback_vregid;
    logic [31:0]             writeback_val;

    rs_div_ooo #(.DEPTH(DEPTH), .NUM_WB(NUM_WB), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .hci_rdy(hci_rdy), .flush(flush), .in_en(in_en),
        .op_type(op_type), .vdest_id(vdest_id),
        .op1_dependent(op1_dependent), .op1(op1),
        .op2_dependent(op2_dependent), .op2(op2),
        .wb_en(wb_en), .wb_vregid(wb_vregid), .wb_val(wb_val),
        .writeback_en(writeback_en), .writeback_vregid(writeback_vregid),
        .writeback_val(writeback_val), .full(full), .div_busy(div_busy)
    );

    // Clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // Scoreboard state
    logic [EW-1:0] exp_q[$];
    int n_vec = 0, n_err = 0, n_push = 0, wb_cnt = 0, wb_cyc = 0, e0 = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
        if (op[0]) return op[1] ? a % b : a / b;
        sa = a;
        sb = b;
        return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    endfunction

    // Monitor: pop and compare every result pulse.
    always @(posedge clk) begin
        logic [EW-1:0] e;
        #1;
        if (writeback_en === 1'b1) begin
            wb_cnt++;
            wb_cyc = cyc;
            check("wb_expected_pending", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("wb_tag", 64'(writeback_vregid), 64'(e[EW-1:32]));
                check("wb_val", 64'(writeback_val), 64'(e[31:0]));
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_wb(input logic [TAG_W-1:0] tag, input logic [31:0] val);
        exp_q.push_back({tag, val});
        n_push++;
    endtask

    task automatic send(input logic [2:0] op, input logic [TAG_W-1:0] tag, input logic d1,
                        input logic [31:0] a, input logic d2, input logic [31:0] b, input bit push);
        in_en = 1'b1; op_type = op; vdest_id = tag;
        op1_dependent = d1; op1 = a; op2_dependent = d2; op2 = b;
        if (push) expect_wb(tag, model(op, a, b));
        tick();
        e0 = cyc;
        in_en = 1'b0;
    endtask

    task automatic wait_wb(input int target, input int budget);
        int n = 0;
        while (wb_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check("wait_wb_in_budget", 64'(wb_cnt >= target), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    logic [2:0]  age_op [4] = '{3'b001, 3'b010, 3'b000, 3'b011};
    logic [31:0] age_a  [4] = '{32'd77, 32'd50, 32'hFFFF_FFAF, 32'hFFFF_FFFF};
    logic [31:0] age_b  [4] = '{32'd7, 32'hFFFF_FFF9, 32'd9, 32'd10};

    initial begin
        int eb, ex, ef, eh;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        rst = 1'b0; hci_rdy = 1'b1; flush = 1'b0; in_en = 1'b0;
        op_type = '0; vdest_id = '0; op1_dependent = 1'b0; op1 = '0;
        op2_dependent = 1'b0; op2 = '0; wb_en = '0; wb_vregid = '0; wb_val = '0;

        // Reset
        tick(); tick();
        check("rst_wb_en", 64'(writeback_en), 64'd0);
        check("rst_full", 64'(full), 64'd0);
        check("rst_busy", 64'(div_busy), 64'd0);
        rst = 1'b1;
        tick();

        // DIVU 100/7 via bypass
        send(3'b001, 5'd3, 1'b0, 32'd100, 1'b0, 32'd7, 1'b1);
        check("bypass_busy", 64'(div_busy), 64'd1);
        wait_wb(n_push, 100);
        check("divu_latency", 64'(wb_cyc - e0), 64'd33);
        check("done_busy_clear", 64'(div_busy), 64'd0);
        tick();
        check("wb_single_pulse", 64'(writeback_en), 64'd0);

        // Signed remainder, early-outs, signed divide
        send(3'b010, 5'd4, 1'b0, 32'hFFFF_FFF9, 1'b0, 32'd2, 1'b1);
        wait_wb(n_push, 100);
        check("rem_latency", 64'(wb_cyc - e0), 64'd33);
        send(3'b000, 5'd5, 1'b0, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1);
        wait_wb(n_push, 100);
        check("ovf_latency", 64'(wb_cyc - e0), 64'd1);
        send(3'b001, 5'd6, 1'b0, 32'd5, 1'b0, 32'd0, 1'b1);
        wait_wb(n_push, 100);
        check("divz_latency", 64'(wb_cyc - e0), 64'd1);
        send(3'b011, 5'd7, 1'b0, 32'd5, 1'b0, 32'd0, 1'b1);
        wait_wb(n_push, 100);
        send(3'b010, 5'd8, 1'b0, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1);
        wait_wb(n_push, 100);
        send(3'b000, 5'd10, 1'b0, 32'hFFFF_FF9C, 1'b0, 32'd7, 1'b1);
        wait_wb(n_push, 100);
        send(3'b010, 5'd10, 1'b0, 32'hFFFF_FF9C, 1'b0, 32'd7, 1'b1);
        wait_wb(n_push, 100);

        // Random ops
        for (int t = 0; t < 4; t++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom_range(1, 1000);
            send(rop, 5'($urandom_range(0, 31)), 1'b0, ra, 1'b0, rb, 1'b1);
            wait_wb(n_push, 100);
            check("rand_latency", 64'(wb_cyc - e0), 64'd33);
        end

        // Wake-up: A waits on tag 9, B bypasses, A issues back-to-back after B
        send(3'b000, 5'd11, 1'b1, 32'd9, 1'b0, 32'd4, 1'b0);
        check("dep_not_bypassed", 64'(div_busy), 64'd0);
        send(3'b001, 5'd12, 1'b0, 32'd50, 1'b0, 32'd5, 1'b1);
        eb = e0;
        wb_en = 3'b100; wb_vregid = {5'd9, 5'd0, 5'd0}; wb_val = {32'd84, 32'd0, 32'd0};
        tick();
        wb_en = '0;
        expect_wb(5'd11, 32'd21);
        wait_wb(n_push, 200);
        check("wake_b2b_latency", 64'(wb_cyc - eb), 64'd66);

        // Simultaneous match: channel 0 wins
        send(3'b011, 5'd13, 1'b1, 32'd9, 1'b0, 32'd7, 1'b0);
        wb_en = 3'b101; wb_vregid = {5'd9, 5'd0, 5'd9}; wb_val = {32'd200, 32'd0, 32'd100};
        tick();
        wb_en = '0;
        expect_wb(5'd13, 32'd2);
        wait_wb(n_push, 100);

        // Same-cycle resolution of an incoming operand enables bypass
        wb_en = 3'b010; wb_vregid = {5'd0, 5'd20, 5'd0}; wb_val = {32'd0, 32'd3, 32'd0};
        send(3'b001, 5'd24, 1'b0, 32'd30, 1'b1, 32'd20, 1'b0);
        wb_en = '0;
        expect_wb(5'd24, 32'd10);
        wait_wb(n_push, 100);
        check("inflight_wake_latency", 64'(wb_cyc - e0), 64'd33);

        // Age order and full
        send(3'b001, 5'd1, 1'b0, 32'd1000, 1'b0, 32'd3, 1'b1);
        ex = e0;
        for (int t = 0; t < 4; t++) send(age_op[t], 5'(14 + t), 1'b0, age_a[t], 1'b0, age_b[t], 1'b1);
        check("age_full_set", 64'(full), 64'd1);
        send(3'b001, 5'd18, 1'b0, 32'd9, 1'b0, 32'd3, 1'b0);
        check("age_full_hold", 64'(full), 64'd1);
        wait_wb(n_push - 4, 100);
        check("age_first_latency", 64'(wb_cyc - ex), 64'd33);
        check("age_full_drop", 64'(full), 64'd0);
        wait_wb(n_push, 300);

        // Flush mid-RUN
        send(3'b001, 5'd19, 1'b0, 32'd1234, 1'b0, 32'd5, 1'b0);
        ef = e0;
        send(3'b000, 5'd21, 1'b1, 32'd25, 1'b0, 32'd3, 1'b0);
        while (cyc < ef + 10) tick();
        flush = 1'b1;
        in_en = 1'b1; op_type = 3'b001; vdest_id = 5'd26;
        op1_dependent = 1'b0; op1 = 32'd8; op2_dependent = 1'b0; op2 = 32'd2;
        tick();
        flush = 1'b0; in_en = 1'b0;
        check("flush_wb_en", 64'(writeback_en), 64'd0);
        check("flush_busy", 64'(div_busy), 64'd0);
        check("flush_full", 64'(full), 64'd0);
        send(3'b001, 5'd22, 1'b0, 32'd999, 1'b0, 32'd9, 1'b1);
        check("post_flush_busy", 64'(div_busy), 64'd1);
        for (int t = 0; t < 3; t++) send(3'b001, 5'(27 + t), 1'b0, 32'(100 + t), 1'b0, 32'd3, 1'b1);
        check("flush_occ_zero", 64'(full), 64'd0);
        send(3'b011, 5'd30, 1'b0, 32'd100, 1'b0, 32'd6, 1'b1);
        check("post_flush_full", 64'(full), 64'd1);
        wb_en = 3'b001; wb_vregid = {5'd0, 5'd0, 5'd25}; wb_val = {32'd0, 32'd0, 32'd6};
        tick();
        wb_en = '0;
        wait_wb(n_push, 300);

        // hci_rdy freeze
        send(3'b001, 5'd23, 1'b0, 32'd1000000, 1'b0, 32'd17, 1'b1);
        eh = e0;
        while (cyc < eh + 10) tick();
        hci_rdy = 1'b0;
        repeat (5) tick();
        hci_rdy = 1'b1;
        wait_wb(n_push, 100);
        check("freeze_latency", 64'(wb_cyc - eh), 64'd38);

        // Drain: nothing further may appear
        repeat (40) tick();
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        check("drain_wb_count", 64'(wb_cnt), 64'(n_push));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/rs_div_ooo.md
Name: rs_div_ooo

Overview:
- Parametrised next-generation divide reservation station for the out-of-order core.
- Holds DEPTH RV32M divide/remainder ops and snoops NUM_WB writeback channels for operand wake-up.
- Issues ready ops oldest-first into an internal radix-2 iterative divider and returns results on a single writeback port.
- Adds flush, a divider-occupancy output and early-out for divide-by-zero and signed overflow.

Parameters:
- DEPTH, 8, number of station entries (power of two, 2..16).
- NUM_WB, 3, number of snooped writeback channels.
- TAG_W, 5, virtual-register tag width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- hci_rdy  in  1  global enable; when 0, every register holds
- flush  in  1  squash all entries and any in-flight divide
- in_en  in  1  new op valid
- op_type  in  3  bit0=unsigned, bit1=remainder (DIV=000, DIVU=001, REM=010, REMU=011)
- vdest_id  in  TAG_W  destination tag
- op1_dependent  in  1  op1[TAG_W-1:0] carries a pending tag
- op1  in  32  dividend value or tag
- op2_dependent  in  1  op2[TAG_W-1:0] carries a pending tag
- op2  in  32  divisor value or tag
- wb_en  in  NUM_WB  per-channel valid
- wb_vregid  in  NUM_WB*TAG_W  channel k tag at bits [k*TAG_W +: TAG_W]
- wb_val  in  NUM_WB*32  channel k value at bits [k*32 +: 32]
- writeback_en  out  1  result valid, one-cycle pulse
- writeback_vregid  out  TAG_W  result tag
- writeback_val  out  32  quotient or remainder
- full  out  1  occupancy == DEPTH (registered)
- div_busy  out  1  divider holds an op (registered)

Behaviour:
Reset and global control
- rst=0 at an edge: all entries invalid, divider idle, writeback_en=0, full=0, div_busy=0. writeback_vregid and writeback_val are reset to 0.
- rst overrides hci_rdy and flush. hci_rdy=0 freezes all state, outputs included.

Wake-up
- A valid entry with a dependent operand whose tag matches a channel with wb_en=1 clears the dependency and latches wb_val on that edge.
- The lowest channel index wins on multiple matches.

Allocation (in_en=1, full=0, flush=0)
- An incoming dependent operand is resolved the same way against the same-cycle writeback channels before storage.
- Bypass: the op goes directly into the divider, without occupying an entry, only when the divider is idle, no entry is ready, and both operands are ready after same-cycle resolution.
- Otherwise the op is written to the lowest-index free entry and becomes the youngest entry.
- in_en while full=1 is ignored.

Issue
- An entry is ready when it is valid and neither operand is dependent. Operands woken on an edge make the entry ready only from the following cycle.
- When the divider is idle, the oldest ready entry (age matrix, no sequence counters) moves into the divider and its entry frees on that edge.

Divider
- FSM states: IDLE -> RUN (32 iterations, one quotient bit per cycle) -> DONE -> IDLE.
- Signed ops divide magnitudes; quotient is negated if signs differ, remainder takes the dividend's sign.
- Latency: op captured at edge E0 -> writeback_en high for exactly the cycle after edge E33.
- Early out: divisor == 0 gives quotient 0xFFFFFFFF and remainder = dividend. Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0. Both go straight to DONE, so writeback_en is high after edge E1.
- The divider returns to IDLE on the DONE edge, so the next op may be captured on that same edge (back-to-back issue).
- div_busy = 1 in RUN and DONE.

Occupancy
- Occupancy is updated once per edge: +1 on allocation, -1 on issue from an entry; both may occur on the same edge.
- full is registered as (next occupancy == DEPTH).

Flush
- Invalidates all entries and returns the FSM to IDLE.
- writeback_en=0 on the following cycle, even if DONE was pending.
- in_en on the flush cycle is dropped; full=0 and div_busy=0 afterwards.

Test Plan:
- Reset: hold rst=0 for 2 cycles -> writeback_en=0, full=0, div_busy=0. Then DIVU 100/7, tag 3, bypass -> writeback_en pulses 34 cycles later with vregid=3, val=14.
- Signed remainder and early-out:
  - REM -7 % 2 -> 0xFFFFFFFF.
  - DIV -0x80000000 / -1 -> 0x80000000 after 2 cycles.
  - DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
- Wake-up:
  - Op A issued while op1 depends on tag 9. A later op B arrives ready.
  - wb channel 2 then broadcasts tag 9 = 84, with op2 = 4.
  - Required: B issues first (A still dependent); A completes with 21.
  - Simultaneous tag 9 on channels 0 and 2 -> channel 0 value used.
- Age order: fill DEPTH=4 with 4 ready ops while the divider is busy -> full=1, in_en ignored, results return in arrival order, full drops after the first issue.
- Flush mid-RUN at cycle 10 -> no writeback_en, div_busy=0, occupancy 0. A new op issued next cycle completes normally.
- hci_rdy=0 for 5 cycles mid-division -> result is delayed by exactly 5 cycles and its value is unchanged.
